clk_gen_multi: RTL and testbench

Parametrised multi-channel clock/tick generator replacing the fixed-ratio divider at the top of the design. It derives N_CH independently programmable 50 %-duty divided clocks, with a one-cycle tick per channel, from the single system clock, and keeps a free-running millisecond system-time counter. Channel ratios and enables are written at run time through a simple write port. Ratio changes and disables are applied glitch-free, at period boundaries.

---
 rtl/clk_gen_pkg.sv | 33 +++
 rtl/clk_gen_channel.sv | 136 +++++++++++++
 rtl/clk_gen_multi.sv | 78 +++++++
 tb/tb_clk_gen_multi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared constants, channel run-state type and sizing helpers
// for the multi-channel clock/tick generator.
//   DEFAULT_HALF : half-period loaded into every channel at reset
//   ch_state_t   : per-channel run state (stopped / running / stopping)
//   ch_w()       : clog2 with a minimum of 1, used for select and counter widths
//   ms_div()     : clk_in cycles per millisecond (MS_DIV = CLK_HZ/1000, at least 1)
package clk_gen_pkg;

    localparam int unsigned DEFAULT_HALF = 25;

    // CH_DRAIN: disable requested while high; stops at the next falling toggle
    typedef enum logic [1:0] {
        CH_STOP  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_t;

    function automatic int unsigned ch_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned ms_div(input int unsigned clk_hz);
        int unsigned d;
        d = clk_hz / 32'd1000;
        return (d == 0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// clk_gen_channel: one divided-clock channel with 50 % duty and a rise tick.
// Ratio changes made while running are held in a shadow register and applied
// at the next falling toggle, so every phase runs to completion (no runts).
// Ports:
//   clk_in, rst_n : system clock, async active-low reset
//   wr            : write strobe already decoded for this channel
//   wr_half       : new half-period (0 is treated as 1)
//   wr_en         : new enable state
//   sync          : shared phase-align strobe
//   clk_out       : divided clock (registered)
//   tick          : one-cycle pulse on the cycle clk_out rises (registered)
module clk_gen_channel
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DEFAULT_HALF = 25
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_half,
    input  logic             wr_en,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick
);
    import clk_gen_pkg::*;

    ch_state_t        state_q,  state_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q,   pend_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic             clk_d;
    logic             tick_d;

    logic [DIV_W-1:0] half_w;
    logic             running;
    logic             term;

    // Zero half-period would never reach terminal count; clamp to 1
    assign half_w  = (wr_half == '0) ? DIV_W'(1) : wr_half;
    assign running = (state_q != CH_STOP);
    assign term    = running && (cnt_q == (active_q - DIV_W'(1)));

    // Next-state: sync first, then writes, then ordinary counting
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        clk_d    = clk_out;
        tick_d   = 1'b0;

        if (sync && wr) begin
            // Written half takes effect at once and the phase restarts from 0
            active_d = half_w;
            shadow_d = half_w;
            pend_d   = 1'b0;
            cnt_d    = '0;
            clk_d    = 1'b0;
            state_d  = wr_en ? CH_RUN : CH_STOP;
        end else if (sync && running) begin
            // Phase align; a pending ratio lands here, a pending disable completes
            if (pend_q) begin
                active_d = shadow_q;
            end
            pend_d  = 1'b0;
            cnt_d   = '0;
            clk_d   = 1'b0;
            state_d = (state_q == CH_DRAIN) ? CH_STOP : CH_RUN;
        end else if (!running) begin
            if (wr) begin
                active_d = half_w;
                shadow_d = half_w;
                pend_d   = 1'b0;
                cnt_d    = '0;
                clk_d    = 1'b0;
                state_d  = wr_en ? CH_RUN : CH_STOP;
            end
        end else if (wr && !wr_en && !clk_out) begin
            // Disable while low: stop now, nothing to truncate
            active_d = half_w;
            shadow_d = half_w;
            pend_d   = 1'b0;
            cnt_d    = '0;
            state_d  = CH_STOP;
        end else begin
            if (wr) begin
                shadow_d = half_w;
                pend_d   = 1'b1;
                // Only reachable with clk_out high when disabling: wait for the fall
                state_d  = wr_en ? CH_RUN : CH_DRAIN;
            end
            if (term) begin
                cnt_d  = '0;
                clk_d  = ~clk_out;
                tick_d = ~clk_out;
                if (clk_out) begin
                    // Falling toggle is the full-period boundary
                    if (pend_d) begin
                        active_d = shadow_d;
                        pend_d   = 1'b0;
                    end
                    if (state_d == CH_DRAIN) begin
                        state_d = CH_STOP;
                    end
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_STOP;
            active_q <= DIV_W'(DEFAULT_HALF);
            shadow_q <= DIV_W'(DEFAULT_HALF);
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            clk_out  <= clk_d;
            tick     <= tick_d;
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: N_CH independently programmable divided clocks with rise
// ticks, plus a free-running millisecond tick and system-time counter.
// Ports:
//   clk_in, rst_n   : system clock, async active-low reset
//   cfg_wr          : one-cycle configuration write strobe
//   cfg_ch          : target channel (out-of-range values are ignored)
//   cfg_half        : new half-period in clk_in cycles (0 acts as 1)
//   cfg_en          : new enable state for cfg_ch
//   sync            : one-cycle phase-align strobe for all enabled channels
//   clk_out, tick   : per-channel divided clock and rise pulse
//   ms_tick         : one-cycle pulse per millisecond
//   system_time_ms  : milliseconds since reset, wraps silently
module clk_gen_multi
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned TIME_W       = 32,
    parameter int unsigned DEFAULT_HALF = clk_gen_pkg::DEFAULT_HALF
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n,
    input  logic                                 cfg_wr,
    input  logic [clk_gen_pkg::ch_w(N_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]                     cfg_half,
    input  logic                                 cfg_en,
    input  logic                                 sync,
    output logic [N_CH-1:0]                      clk_out,
    output logic [N_CH-1:0]                      tick,
    output logic                                 ms_tick,
    output logic [TIME_W-1:0]                    system_time_ms
);
    import clk_gen_pkg::*;

    localparam int unsigned CH_W    = ch_w(N_CH);
    localparam int unsigned MS_DIV  = ms_div(CLK_HZ);
    localparam int unsigned PRESC_W = ch_w(MS_DIV);

    logic [PRESC_W-1:0] presc_q;

    // One channel per output bit; the write strobe is decoded per channel
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

        clk_gen_channel #(
            .DIV_W        (DIV_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .wr      (wr_sel),
            .wr_half (cfg_half),
            .wr_en   (cfg_en),
            .sync    (sync),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

    // Millisecond prescaler; ms_tick coincides with the time increment
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            ms_tick        <= 1'b0;
            system_time_ms <= '0;
        end else if (presc_q == PRESC_W'(MS_DIV - 1)) begin
            presc_q        <= '0;
            ms_tick        <= 1'b1;
            system_time_ms <= system_time_ms + TIME_W'(1);
        end else begin
            presc_q        <= presc_q + PRESC_W'(1);
            ms_tick        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: scoreboard bench for clk_gen_multi (3 channels,
// CLK_HZ = 10 kHz so one millisecond is 10 cycles, 4-bit system time).
// Stimulus pushes hand-derived expected events (clk_out edges, ticks,
// ms ticks) into queues; a monitor pops and compares whenever the DUT
// shows an event.
module tb_clk_gen_multi;

    localparam int N_CH   = 3;
    localparam int DIV_W  = 16;
    localparam int TIME_W = 4;
    localparam int CH_W   = 2;

    logic              clk_in;
    logic              rst_n;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic              cfg_en;
    logic              sync;
    logic [N_CH-1:0]   clk_out;
    logic [N_CH-1:0]   tick;
    logic              ms_tick;
    logic [TIME_W-1:0] system_time_ms;

    clk_gen_multi #(
        .CLK_HZ       (10_000),
        .N_CH         (N_CH),
        .DIV_W        (DIV_W),
        .TIME_W       (TIME_W),
        .DEFAULT_HALF (25)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .cfg_wr         (cfg_wr),
        .cfg_ch         (cfg_ch),
        .cfg_half       (cfg_half),
        .cfg_en         (cfg_en),
        .sync           (sync),
        .clk_out        (clk_out),
        .tick           (tick),
        .ms_tick        (ms_tick),
        .system_time_ms (system_time_ms)
    );

    typedef struct { int c; logic v; } edge_ev_t;
    typedef struct { int c; int t; } ms_ev_t;

    edge_ev_t q_edge[N_CH][$];
    int       q_tick[N_CH][$];
    ms_ev_t   q_ms[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_edge(input int ch, input int c, input logic v);
        edge_ev_t ev;
        ev.c = c;
        ev.v = v;
        q_edge[ch].push_back(ev);
    endtask

    // One full high phase: rise with tick at r, fall at f
    task automatic push_pulse(input int ch, input int r, input int f);
        push_edge(ch, r, 1'b1);
        q_tick[ch].push_back(r);
        push_edge(ch, f, 1'b0);
    endtask

    task automatic push_ms(input int base, input int n);
        ms_ev_t mv;
        for (int k = 1; k <= n; k++) begin
            mv.c = base + 10 * k;
            mv.t = k % 16;
            q_ms.push_back(mv);
        end
    endtask

    // Wait so that the next write/sync is sampled at edge n
    task automatic at(input int n);
        while (cyc < n - 1) @(negedge clk_in);
    endtask

    task automatic wr(input int ch, input int half, input logic en);
        cfg_ch   = CH_W'(ch);
        cfg_half = DIV_W'(half);
        cfg_en   = en;
        cfg_wr   = 1'b1;
        @(negedge clk_in);
        cfg_wr   = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        @(negedge clk_in);
        sync = 1'b0;
    endtask

    // Any expected event already due but not seen is a miss
    task automatic drain_check();
        edge_ev_t ev;
        ms_ev_t   mv;
        int       tc;
        for (int ch = 0; ch < N_CH; ch++) begin
            while (q_edge[ch].size() > 0 && q_edge[ch][0].c <= cyc) begin
                ev = q_edge[ch].pop_front();
                n_chk++;
                $display("FAIL missing_edge_ch%0d: got none, expected edge to %0b at cycle %0d", ch, ev.v, ev.c);
            end
            while (q_tick[ch].size() > 0 && q_tick[ch][0] <= cyc) begin
                tc = q_tick[ch].pop_front();
                n_chk++;
                $display("FAIL missing_tick_ch%0d: got none, expected tick at cycle %0d", ch, tc);
            end
        end
        while (q_ms.size() > 0 && q_ms[0].c <= cyc) begin
            mv = q_ms.pop_front();
            n_chk++;
            $display("FAIL missing_ms_tick: got none, expected ms_tick at cycle %0d", mv.c);
        end
    endtask

    task automatic monitor();
        logic [N_CH-1:0] prev;
        edge_ev_t        ev;
        ms_ev_t          mv;
        int              tc;
        prev = '0;
        forever begin
            @(negedge clk_in);
            if (rst_n) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (clk_out[ch] != prev[ch]) begin
                        if (q_edge[ch].size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_edge_ch%0d: got edge to %0b at cycle %0d, expected none", ch, clk_out[ch], cyc);
                        end else begin
                            ev = q_edge[ch].pop_front();
                            chk($sformatf("edge_cycle_ch%0d", ch), cyc, ev.c);
                            chk($sformatf("edge_level_ch%0d", ch), int'(clk_out[ch]), int'(ev.v));
                        end
                    end
                    if (tick[ch]) begin
                        if (q_tick[ch].size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_tick_ch%0d: got tick at cycle %0d, expected none", ch, cyc);
                        end else begin
                            tc = q_tick[ch].pop_front();
                            chk($sformatf("tick_cycle_ch%0d", ch), cyc, tc);
                        end
                    end
                end
                if (ms_tick) begin
                    if (q_ms.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_ms_tick: got ms_tick at cycle %0d, expected none", cyc);
                    end else begin
                        mv = q_ms.pop_front();
                        chk("ms_tick_cycle", cyc, mv.c);
                        chk("system_time_ms", int'(system_time_ms), mv.t);
                    end
                end
            end
            prev = clk_out;
        end
    endtask

    initial begin
        int e, e2, e3, s, s2, rel, rel2;

        rst_n    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_half = '0;
        cfg_en   = 1'b0;
        sync     = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk_in);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_ms_tick", int'(ms_tick), 0);
        chk("rst_system_time", int'(system_time_ms), 0);
        rst_n = 1'b1;
        rel = cyc;
        push_ms(rel, 200);

        // ch0 half=25: first rise 25 edges after the write, period 50
        e = cyc + 2;
        push_pulse(0, e + 25, e + 50);
        push_pulse(0, e + 75, e + 100);
        at(e);       wr(0, 25, 1'b1);
        at(e + 111); wr(0, 25, 1'b0);     // low: stops at once
        at(e + 131);
        chk("ch0_stopped", int'(clk_out), 0);

        // ch1 half=10, retarget to 3 during a high phase
        e = cyc + 2;
        push_pulse(1, e + 10, e + 20);
        push_pulse(1, e + 30, e + 40);    // high phase kept at 10
        push_pulse(1, e + 43, e + 46);
        push_pulse(1, e + 49, e + 52);
        at(e);      wr(1, 10, 1'b1);
        at(e + 33); wr(1, 3, 1'b1);
        at(e + 53); wr(1, 3, 1'b0);

        // ch2 half=5: disable at cnt=1 of the high phase waits for the fall
        e = cyc + 2;
        push_pulse(2, e + 5, e + 10);
        push_pulse(2, e + 15, e + 20);
        at(e);      wr(2, 5, 1'b1);
        at(e + 17); wr(2, 5, 1'b0);
        e2 = e + 30;
        push_pulse(2, e2 + 5, e2 + 10);
        at(e2);      wr(2, 5, 1'b1);
        at(e2 + 12); wr(2, 5, 1'b0);      // low: no further tick
        // disable while high, re-enabled before the fall: keeps running
        e3 = e2 + 30;
        push_pulse(2, e3 + 5, e3 + 10);
        push_pulse(2, e3 + 15, e3 + 20);
        at(e3);      wr(2, 5, 1'b1);
        at(e3 + 6);  wr(2, 5, 1'b0);
        at(e3 + 8);  wr(2, 5, 1'b1);
        at(e3 + 22); wr(2, 5, 1'b0);

        // sync with ch0 half=4 and ch1 half=7 (ch1 enabled one edge later)
        e = cyc + 2;
        s = e + 13;
        s2 = s + 12;                      // ch0 at terminal count here
        push_pulse(0, e + 4, e + 8);
        push_pulse(0, e + 12, s);
        push_pulse(0, s + 4, s + 8);
        push_pulse(0, s2 + 4, s2 + 8);
        push_pulse(1, e + 8, s);
        push_pulse(1, s + 7, s2);
        push_pulse(1, s2 + 7, s2 + 14);
        at(e);       wr(0, 4, 1'b1);
        wr(1, 7, 1'b1);
        at(s);       do_sync();
        at(s2);      do_sync();
        at(s2 + 9);  wr(0, 4, 1'b0);
        at(s2 + 15); wr(1, 7, 1'b0);

        // half=0 acts as half=1; disable while high ends on that fall
        e = cyc + 2;
        push_pulse(2, e + 1, e + 2);
        push_pulse(2, e + 3, e + 4);
        push_pulse(2, e + 5, e + 6);
        at(e);     wr(2, 0, 1'b1);
        at(e + 6); wr(2, 0, 1'b0);

        // out-of-range channel select changes nothing
        at(cyc + 2); wr(3, 2, 1'b1);
        repeat (20) @(negedge clk_in);
        chk("bad_ch_clk_out", int'(clk_out), 0);
        chk("bad_ch_tick", int'(tick), 0);

        // async reset between edges, mid prescaler count
        while (((cyc - rel) % 10) != 4) @(negedge clk_in);
        @(posedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_system_time", int'(system_time_ms), 0);
        chk("async_rst_ms_tick", int'(ms_tick), 0);
        chk("async_rst_clk_out", int'(clk_out), 0);
        chk("async_rst_tick", int'(tick), 0);
        drain_check();
        q_ms.delete();
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        rel2 = cyc;
        push_ms(rel2, 20);                // includes the 15 -> 0 wrap
        at(rel2 + 176);
        #1;
        drain_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
